// File: rtl/fp_normalizer.sv
// Post-add/sub normalization stage: shifts the raw sum mantissa until the hidden bit is set and adjusts the exponent.
// Optional round-to-nearest-even after a right shift is enabled by defining FP_NORM_ROUND_EN.
module fp_normalizer #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [Mantissa_Size+1:0]   sum_mantissa,
    input  logic [Exponent_Size-1:0]   exponent_in,
    input  logic                       sign_in,
    output logic [Mantissa_Size-1:0]   mantissa_out,
    output logic [Exponent_Size-1:0]   exponent_out,
    output logic                       sign_out,
    output logic                       busy,
    output logic                       done,
    output logic                       zero,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int MW = Mantissa_Size + 2;
    localparam logic [Exponent_Size-1:0] EXP_MAX  = {Exponent_Size{1'b1}};
    localparam logic [Exponent_Size-1:0] EXP_ZERO = {Exponent_Size{1'b0}};
    localparam logic [Exponent_Size-1:0] EXP_ONE  = {{(Exponent_Size-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        SHIFT_L = 3'd2,
        SHIFT_R = 3'd3,
        ROUND   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                   state_r, state_s;
    logic [MW-1:0]            mant_r, mant_s;
    logic [Exponent_Size-1:0] exp_r, exp_s;
    logic                     sign_r, sign_s;
    logic                     busy_r, busy_s;
    logic                     done_r, done_s;
    logic                     zero_r, zero_s;
    logic                     overflow_r, overflow_s;
    logic                     underflow_r, underflow_s;
    logic [MW-1:0]            shl_s, shr_s;
    logic [Exponent_Size-1:0] exp_dec_s, exp_inc_s;
`ifdef FP_NORM_ROUND_EN
    logic                     guard_r, guard_s;
    logic [MW-1:0]            rnd_s;

    assign rnd_s = mant_r + {{(MW-1){1'b0}}, 1'b1};
`endif

    assign shl_s     = {mant_r[MW-2:0], 1'b0};
    assign shr_s     = {1'b0, mant_r[MW-1:1]};
    assign exp_dec_s = exp_r - EXP_ONE;
    // Increment saturates so the exponent can never wrap past infinity
    assign exp_inc_s = (exp_r == EXP_MAX) ? EXP_MAX : exp_r + EXP_ONE;

    // Next-state and datapath update
    always_comb begin
        state_s     = state_r;
        mant_s      = mant_r;
        exp_s       = exp_r;
        sign_s      = sign_r;
        zero_s      = zero_r;
        overflow_s  = overflow_r;
        underflow_s = underflow_r;
`ifdef FP_NORM_ROUND_EN
        guard_s     = guard_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s     = CHECK;
                    mant_s      = sum_mantissa;
                    exp_s       = exponent_in;
                    sign_s      = sign_in;
                    zero_s      = 1'b0;
                    overflow_s  = 1'b0;
                    underflow_s = 1'b0;
`ifdef FP_NORM_ROUND_EN
                    guard_s     = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if (mant_r == {MW{1'b0}}) begin
                    zero_s  = 1'b1;
                    exp_s   = EXP_ZERO;
                    state_s = DONE;
                end else if (mant_r[MW-1]) begin
                    state_s = SHIFT_R;
                end else if (mant_r[MW-2]) begin
                    state_s = DONE;
                end else if (exp_r == EXP_ZERO) begin
                    underflow_s = 1'b1;
                    zero_s      = 1'b1;
                    mant_s      = {MW{1'b0}};
                    state_s     = DONE;
                end else begin
                    state_s = SHIFT_L;
                end
            end
            SHIFT_L: begin
                mant_s = shl_s;
                exp_s  = exp_dec_s;
                if (shl_s[MW-2]) begin
                    state_s = DONE;
                end else if (exp_dec_s == EXP_ZERO) begin
                    underflow_s = 1'b1;
                    zero_s      = 1'b1;
                    mant_s      = {MW{1'b0}};
                    state_s     = DONE;
                end else begin
                    state_s = SHIFT_L;
                end
            end
            SHIFT_R: begin
                mant_s  = shr_s;
                exp_s   = exp_inc_s;
                state_s = DONE;
`ifdef FP_NORM_ROUND_EN
                guard_s = mant_r[0];
`endif
                if (exp_inc_s == EXP_MAX) begin
                    overflow_s                = 1'b1;
                    mant_s[Mantissa_Size-1:0] = {Mantissa_Size{1'b0}};
                end else begin
`ifdef FP_NORM_ROUND_EN
                    state_s = ROUND;
`else
                    state_s = DONE;
`endif
                end
            end
`ifdef FP_NORM_ROUND_EN
            ROUND: begin
                state_s = DONE;
                // Guard is an exact half here, so ties go to even via the LSB
                if (guard_r && mant_r[0]) begin
                    if (rnd_s[MW-1]) begin
                        mant_s = {1'b0, rnd_s[MW-1:1]};
                        exp_s  = exp_inc_s;
                        if (exp_inc_s == EXP_MAX) begin
                            overflow_s                = 1'b1;
                            mant_s[Mantissa_Size-1:0] = {Mantissa_Size{1'b0}};
                        end else begin
                            overflow_s = overflow_r;
                        end
                    end else begin
                        mant_s = rnd_s;
                    end
                end else begin
                    mant_s = mant_r;
                end
            end
`endif
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == CHECK) || (state_s == SHIFT_L) ||
                 (state_s == SHIFT_R) || (state_s == ROUND);
        done_s = (state_s == DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mant_r      <= {MW{1'b0}};
            exp_r       <= EXP_ZERO;
            sign_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
`ifdef FP_NORM_ROUND_EN
            guard_r     <= 1'b0;
`endif
        end else begin
            mant_r      <= mant_s;
            exp_r       <= exp_s;
            sign_r      <= sign_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            zero_r      <= zero_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
`ifdef FP_NORM_ROUND_EN
            guard_r     <= guard_s;
`endif
        end
    end

    assign mantissa_out = mant_r[Mantissa_Size-1:0];
    assign exponent_out = exp_r;
    assign sign_out     = sign_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign zero         = zero_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed table-driven bench for fp_normalizer (23-bit fraction, 8-bit exponent), plus reset-abort and start-ignore sequences.
module tb_fp_normalizer;

`ifdef FP_NORM_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [24:0] sum_mantissa;
    logic [7:0]  exponent_in;
    logic        sign_in;
    logic [22:0] mantissa_out;
    logic [7:0]  exponent_out;
    logic        sign_out;
    logic        busy;
    logic        done;
    logic        zero;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int fails  = 0;
    int cur_idx = 0;

    fp_normalizer #(.Mantissa_Size(23), .Exponent_Size(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sum_mantissa (sum_mantissa),
        .exponent_in  (exponent_in),
        .sign_in      (sign_in),
        .mantissa_out (mantissa_out),
        .exponent_out (exponent_out),
        .sign_out     (sign_out),
        .busy         (busy),
        .done         (done),
        .zero         (zero),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] sum;
        logic [7:0]  exp;
        logic        sign;
        logic [22:0] e_frac;
        logic [7:0]  e_exp;
        logic        e_zero;
        logic        e_ov;
        logic        e_un;
        int          e_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, cur_idx, act, req);
        end
    endtask

    // Apply one operand with start in cycle 0 and check the result and latency
    task automatic run(input vec_t v);
        int n;
        @(negedge clk);
        start = 1'b1; sum_mantissa = v.sum; exponent_in = v.exp; sign_in = v.sign;
        @(negedge clk);
        start = 1'b0; sum_mantissa = 25'h1555555; exponent_in = 8'hA5; sign_in = ~v.sign;
        n = 1;
        chk("busy_cycle1", {31'd0, busy}, 32'd1);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, v.e_lat);
        chk("frac", {9'd0, mantissa_out}, {9'd0, v.e_frac});
        chk("exp", {24'd0, exponent_out}, {24'd0, v.e_exp});
        chk("sign", {31'd0, sign_out}, {31'd0, v.sign});
        chk("zero", {31'd0, zero}, {31'd0, v.e_zero});
        chk("overflow", {31'd0, overflow}, {31'd0, v.e_ov});
        chk("underflow", {31'd0, underflow}, {31'd0, v.e_un});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("hold_frac", {9'd0, mantissa_out}, {9'd0, v.e_frac});
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int done_seen;
        vecs[0]  = '{25'h0800000, 8'd127, 1'b0, 23'h0,      8'd127, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{25'h0020000, 8'd127, 1'b1, 23'h0,      8'd121, 1'b0, 1'b0, 1'b0, 8};
        vecs[2]  = '{25'h1000003, 8'd127, 1'b0, (RND != 0) ? 23'h2 : 23'h1, 8'd128, 1'b0, 1'b0, 1'b0, 3 + RND};
        vecs[3]  = '{25'h0000000, 8'd90,  1'b1, 23'h0,      8'd0,   1'b1, 1'b0, 1'b0, 2};
        vecs[4]  = '{25'h1000000, 8'd254, 1'b0, 23'h0,      8'd255, 1'b0, 1'b1, 1'b0, 3};
        vecs[5]  = '{25'h0000001, 8'd5,   1'b0, 23'h0,      8'd0,   1'b1, 1'b0, 1'b1, 7};
        vecs[6]  = '{25'h0C00001, 8'd100, 1'b1, 23'h400001, 8'd100, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{25'h0400000, 8'd0,   1'b0, 23'h0,      8'd0,   1'b1, 1'b0, 1'b1, 2};
        vecs[8]  = '{25'h1FFFFFF, 8'd10,  1'b0, (RND != 0) ? 23'h0 : 23'h7FFFFF,
                     (RND != 0) ? 8'd12 : 8'd11, 1'b0, 1'b0, 1'b0, 3 + RND};
        vecs[9]  = '{25'h1000002, 8'd3,   1'b1, 23'h1,      8'd4,   1'b0, 1'b0, 1'b0, 3 + RND};
        vecs[10] = '{25'h0400000, 8'd2,   1'b0, 23'h0,      8'd1,   1'b0, 1'b0, 1'b0, 3};
        vecs[11] = '{25'h0400000, 8'd1,   1'b0, 23'h0,      8'd0,   1'b0, 1'b0, 1'b0, 3};
        vecs[12] = '{25'h1000000, 8'd255, 1'b1, 23'h0,      8'd255, 1'b0, 1'b1, 1'b0, 3};

        reset = 1'b1; start = 1'b0; sum_mantissa = 25'h0; exponent_in = 8'd0; sign_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cur_idx = -1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {29'd0, zero, overflow, underflow}, 32'd0);
        chk("rst_frac", {9'd0, mantissa_out}, 32'd0);
        chk("rst_exp", {24'd0, exponent_out}, 32'd0);
        chk("rst_sign", {31'd0, sign_out}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            cur_idx = i;
            run(vecs[i]);
        end

        // Reset pulsed in cycle 4 of an underflow run aborts it
        cur_idx = 100;
        @(negedge clk);
        start = 1'b1; sum_mantissa = 25'h0000001; exponent_in = 8'd5; sign_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_regs", {8'd0, mantissa_out, sign_out}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", done_seen, 0);

        // start held high while busy with other data must be ignored
        cur_idx = 101;
        @(negedge clk);
        start = 1'b1; sum_mantissa = 25'h0020000; exponent_in = 8'd127; sign_in = 1'b0;
        @(negedge clk);
        sum_mantissa = 25'h0000000; exponent_in = 8'd3; sign_in = 1'b1;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("ign_latency", n, 8);
        chk("ign_exp", {24'd0, exponent_out}, 32'd121);
        chk("ign_zero", {31'd0, zero}, 32'd0);
        chk("ign_sign", {31'd0, sign_out}, 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
